// File: rtl/circuit1_sched.sv
// circuit1_sched: multi-cycle scheduler for z = max(A+B, A+C) and x = A*C - (A+B).
// One adder/subtractor and one multiplier are time-shared under a five-state FSM.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; operands latched on the start edge
//   S1    | d = A+B (truncated), f = A*C (full width)
//   S2    | e = A+C (truncated)
//   S3    | Z = max(d, e), X = f - d (adder in subtract mode)
//   DONE  | results valid, done pulses for this single cycle
module circuit1_sched #(
    parameter int DATAW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAW-1:0]     A,
    input  logic [DATAW-1:0]     B,
    input  logic [DATAW-1:0]     C,
    output logic                 busy,
    output logic                 done,
    output logic [DATAW-1:0]     Z,
    output logic [2*DATAW-1:0]   X
);

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S2,
        S3,
        DONE
    } state_t;

    state_t state;

    logic [DATAW-1:0]   a_r;
    logic [DATAW-1:0]   b_r;
    logic [DATAW-1:0]   c_r;
    logic [DATAW-1:0]   d_r;
    logic [DATAW-1:0]   e_r;
    logic [2*DATAW-1:0] f_r;

    logic [2*DATAW-1:0] alu_a;
    logic [2*DATAW-1:0] alu_b;
    logic [2*DATAW-1:0] alu_y;
    logic               alu_sub;
    logic [2*DATAW-1:0] mul_y;

    // Operand steering for the single shared adder/subtractor, selected by state.
    always_comb begin
        alu_a   = {{DATAW{1'b0}}, a_r};
        alu_b   = {{DATAW{1'b0}}, b_r};
        alu_sub = 1'b0;
        case (state)
            S2: begin
                alu_b = {{DATAW{1'b0}}, c_r};
            end
            S3: begin
                alu_a   = f_r;
                alu_b   = {{DATAW{1'b0}}, d_r};
                alu_sub = 1'b1;
            end
            default: ;
        endcase
        alu_y = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    // Single multiplier; only its S1 result is captured.
    assign mul_y = {{DATAW{1'b0}}, a_r} * {{DATAW{1'b0}}, c_r};

    // Sequencer with registered busy/done and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= '0;
            d_r   <= '0;
            e_r   <= '0;
            f_r   <= '0;
            Z     <= '0;
            X     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        c_r   <= C;
                        busy  <= 1'b1;
                        state <= S1;
                    end
                end
                S1: begin
                    d_r   <= alu_y[DATAW-1:0];
                    f_r   <= mul_y;
                    state <= S2;
                end
                S2: begin
                    e_r   <= alu_y[DATAW-1:0];
                    state <= S3;
                end
                S3: begin
                    Z     <= (d_r > e_r) ? d_r : e_r;
                    X     <= alu_y;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
